compressed_fetch_aligner: RTL

//  Halfword realignment buffer between instruction fetch and the compressed decoder.
//  - Accepts word-aligned 32-bit fetch words.
//  - Splits them into a circular halfword queue.
//  - Emits one instruction per handshake: 16-bit compressed (zero-extended) or 32-bit, including 32-bit words straddling a fetch word.
//  - Tracks the PC of the emitted instruction and supports flush/redirect to any halfword-aligned target.

---
 rtl/compressed_fetch_aligner.sv | 103 ++++++++++
 1 files changed

// File: rtl/compressed_fetch_aligner.sv
// Halfword realignment queue between instruction fetch and the compressed decoder.
// Optional InstIllegal output is built when CFA_ILLEGAL_CHECK_EN is defined.
module compressed_fetch_aligner #(
  parameter int          BUF_HALFWORDS = 4,
  parameter logic [31:0] RESET_PC      = 32'h0
) (
  input  logic        Clk,
  input  logic        nReset,
  input  logic        FetchValid,
  output logic        FetchReady,
  input  logic [31:0] FetchData,
  input  logic        Flush,
  input  logic [31:0] FlushPc,
  output logic        InstValid,
  input  logic        InstReady,
  output logic [31:0] InstData,
  output logic [31:0] InstPc,
  output logic        InstCompressed
`ifdef CFA_ILLEGAL_CHECK_EN
  ,
  output logic        InstIllegal
`endif
);

  localparam int PW = $clog2(BUF_HALFWORDS);
  localparam int CW = PW + 1;

  logic [15:0]   buf_q [BUF_HALFWORDS];
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic [CW-1:0] count;
  logic          skip_low;
  logic [31:0]   pc;

  logic [15:0]   h0;
  logic [15:0]   h1;
  logic          is_comp;
  logic          has_data;
  logic          accept;
  logic          pop;
  logic [CW-1:0] push_n;
  logic [CW-1:0] pop_n;

  // Handshakes: a transfer happens on a cycle where valid and ready are both 1;
  // the producer holds its payload stable until then, and neither side's ready
  // depends on the other side's valid (outputs come from registers, Flush only gates).
  assign h0       = buf_q[rd_ptr];
  assign h1       = buf_q[rd_ptr + PW'(1)];
  assign is_comp  = (h0[1:0] != 2'b11);
  assign has_data = (count != '0);

  assign FetchReady     = !Flush && (count <= CW'(BUF_HALFWORDS - 2));
  assign InstValid      = !Flush && (is_comp ? (count >= CW'(1)) : (count >= CW'(2)));
  assign InstCompressed = has_data && is_comp;
  assign InstData       = !has_data ? 32'h0 : (is_comp ? {16'h0, h0} : {h1, h0});
  assign InstPc         = pc;

`ifdef CFA_ILLEGAL_CHECK_EN
  // All-zero halfword is defined-illegal; xxx11111 marks 48-bit-or-longer encodings.
  assign InstIllegal = has_data && ((h0 == 16'h0000) || (h0[4:0] == 5'b11111));
`endif

  assign accept = FetchValid && FetchReady;
  assign pop    = InstValid && InstReady;
  assign push_n = !accept ? CW'(0) : (skip_low ? CW'(1) : CW'(2));
  assign pop_n  = !pop ? CW'(0) : (is_comp ? CW'(1) : CW'(2));

  always_ff @(posedge Clk or negedge nReset) begin
    if (!nReset) begin
      for (int i = 0; i < BUF_HALFWORDS; i++) buf_q[i] <= '0;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
      skip_low <= 1'b0;
      pc       <= RESET_PC;
    end else if (Flush) begin
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
      skip_low <= FlushPc[1];
      pc       <= {FlushPc[31:1], 1'b0};
    end else begin
      if (accept) begin
        // A redirect into the upper half of a word drops that word's low halfword.
        if (skip_low) begin
          buf_q[wr_ptr] <= FetchData[31:16];
          wr_ptr        <= wr_ptr + PW'(1);
          skip_low      <= 1'b0;
        end else begin
          buf_q[wr_ptr]          <= FetchData[15:0];
          buf_q[wr_ptr + PW'(1)] <= FetchData[31:16];
          wr_ptr                 <= wr_ptr + PW'(2);
        end
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PW'(pop_n);
        pc     <= pc + (is_comp ? 32'd2 : 32'd4);
      end
      count <= count + push_n - pop_n;
    end
  end

endmodule
